counter_job_sequencer: RTL and testbench

//  Controller for the 4-bit up/down counter. Queues counting jobs {start, end, dir}.

---
 rtl/counter_seq_pkg.sv | 24 ++
 rtl/counter_seq_fifo.sv | 69 ++++++
 rtl/counter_job_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_counter_job_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types for the counter job sequencer: FSM state encoding, queued job record
// and the default counter width the job record is sized for.
// No logic, no latency, no backpressure; types only.
package counter_seq_pkg;

    // Width of the counter being sequenced; job_t fields are sized from this.
    localparam int CNT_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } seq_state_e;

    // One counting job: load start_val, count in direction up until end_val.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] start_val;
        logic [CNT_W_DEF-1:0] end_val;
        logic                 up;
    } job_t;

endpackage

// File: rtl/counter_seq_fifo.sv
// Synchronous FIFO of job_t records; head is the oldest entry, shown combinationally.
// Latency: a pushed entry is visible on head/empty the cycle after the push edge.
// Backpressure: push is ignored while full (even with a same-cycle pop); pop ignored while empty.
//
// Ports: clk, rst_n (async active-low), push/push_data, pop, head, full, empty,
//        level (entries held, 0..DEPTH).
module counter_seq_fifo
    import counter_seq_pkg::*;
#(
    parameter int DEPTH = 4          // power of two, >= 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  job_t                     push_data,
    input  logic                     pop,
    output job_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    job_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt;
    logic            do_push;
    logic            do_pop;

    // Full is judged on the current count only, so a pop in the same cycle
    // never frees a slot for a simultaneous push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign level = cnt;

endmodule

// File: rtl/counter_job_sequencer.sv
// Queues {start,end,dir} jobs and runs them one at a time on an external up/down counter,
// pulsing done on reaching end and err when the watchdog (or optional abort) drops a job.
// Latency: LOAD starts one edge after the accepting edge; done/err pulse one cycle after match/timeout.
// Backpressure: job_ready = queue not full; pushes are refused while full, even during a pop.
//
// Ports: CLK, reset (async, active-low); job_valid/job_ready/job_start/job_end/job_up (command side);
//        cnt_value in, cnt_load/cnt_load_en/cnt_chnge/cnt_en/cnt_reset out (counter side);
//        busy, done, err, jobs_done (status).
// Build option: define COUNTER_SEQ_ABORT_EN to add the `abort` input, which forces a running
//               or loading job into ERR on the next edge.
module counter_job_sequencer
    import counter_seq_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,  // must match CNT_W_DEF, which sizes job_t
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 32          // must exceed 2**CNT_W so any reachable end is met
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [CNT_W-1:0] job_start,
    input  logic [CNT_W-1:0] job_end,
    input  logic             job_up,
    input  logic [CNT_W-1:0] cnt_value,
`ifdef COUNTER_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [CNT_W-1:0] cnt_load,
    output logic             cnt_load_en,
    output logic             cnt_chnge,
    output logic             cnt_en,
    output logic             cnt_reset,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       jobs_done
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    seq_state_e  state;
    seq_state_e  state_nxt;
    logic [TW-1:0] timer;
    logic        dir_q;       // direction of the most recently loaded job
    logic [7:0]  done_cnt;

    job_t        q_in;
    job_t        head;
    logic        q_full;
    logic        q_empty;
    logic [LW-1:0] q_level;
    logic        q_push;
    logic        q_pop;

    logic        abort_req;
    logic        end_hit;
    logic        more_queued;

`ifdef COUNTER_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Job queue. The job being executed stays at the head until DONE/ERR.
    // ------------------------------------------------------------------
    assign q_in.start_val = job_start;
    assign q_in.end_val   = job_end;
    assign q_in.up        = job_up;

    assign job_ready = !q_full;
    assign q_push    = job_valid && job_ready;
    assign q_pop     = (state == DONE) || (state == ERR);

    counter_seq_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (reset),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty),
        .level     (q_level)
    );

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    assign end_hit = (cnt_value == head.end_val);

    // In DONE/ERR the head is the finishing job; a second entry means the
    // next job can be loaded straight away without passing through IDLE.
    assign more_queued = (q_level > LW'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!q_empty) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (abort_req) begin
                    state_nxt = ERR;
                end else if (head.start_val == head.end_val) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_nxt = ERR;
                end else if (end_hit) begin
                    state_nxt = DONE;
                end else if (timer == TIMER_LAST) begin
                    state_nxt = ERR;
                end
            end
            DONE, ERR: begin
                state_nxt = more_queued ? LOAD : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Watchdog: counts RUN cycles; cleared on every load so each job gets a full budget.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (state == LOAD) begin
            timer <= '0;
        end else if (state == RUN) begin
            timer <= timer + 1'b1;
        end
    end

    // Direction is remembered so the counter keeps the last job's direction while idle.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            dir_q <= 1'b1;
        end else if (state == LOAD) begin
            dir_q <= head.up;
        end
    end

    // Completed-job counter, free-running modulo 256; dropped jobs do not count.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            done_cnt <= 8'd0;
        end else if (state == DONE) begin
            done_cnt <= done_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Counter-side controls and status, decoded from the current state.
    // ------------------------------------------------------------------
    assign cnt_load_en = (state == LOAD);
    assign cnt_load    = (state == LOAD) ? head.start_val : '0;
    assign cnt_chnge   = (state == LOAD) ? head.up : dir_q;
    // Enable drops in the very cycle the end value is seen so the counter stops on it.
    assign cnt_en      = (state == RUN) && !end_hit;
    assign cnt_reset   = (state == ERR);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign err         = (state == ERR);
    assign jobs_done   = done_cnt;

endmodule

// File: tb/tb_counter_job_sequencer.sv
module tb_counter_job_sequencer;

    localparam int CNT_W   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;
    localparam int MASK    = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             reset = 1'b0;
    logic             job_valid = 1'b0;
    logic             job_ready;
    logic [CNT_W-1:0] job_start = '0;
    logic [CNT_W-1:0] job_end = '0;
    logic             job_up = 1'b0;
    logic [CNT_W-1:0] cnt_value = '0;
    logic [CNT_W-1:0] cnt_load;
    logic             cnt_load_en, cnt_chnge, cnt_en, cnt_reset;
    logic             busy, done, err;
    logic [7:0]       jobs_done;
`ifdef COUNTER_SEQ_ABORT_EN
    logic             abort = 1'b0;
`endif

    always #5 CLK = ~CLK;

    counter_job_sequencer #(
        .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_start(job_start), .job_end(job_end), .job_up(job_up),
        .cnt_value(cnt_value),
`ifdef COUNTER_SEQ_ABORT_EN
        .abort(abort),
`endif
        .cnt_load(cnt_load), .cnt_load_en(cnt_load_en), .cnt_chnge(cnt_chnge),
        .cnt_en(cnt_en), .cnt_reset(cnt_reset),
        .busy(busy), .done(done), .err(err), .jobs_done(jobs_done)
    );

    // External 4-bit up/down counter; freeze makes it ignore enable (stalled datapath).
    logic freeze = 1'b0;
    always @(posedge CLK) begin
        if (cnt_reset)        cnt_value <= '0;
        else if (cnt_load_en) cnt_value <= cnt_load;
        else if (cnt_en && !freeze)
            cnt_value <= cnt_chnge ? cnt_value + 4'd1 : cnt_value - 4'd1;
    end

    // ---------------- checking bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int t = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, t);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each job is scheduled arithmetically: its load cycle L is fixed when it
    // becomes eligible, and its finish cycle F follows from the number of counts
    // needed (modular distance) or the watchdog budget when the counter is stalled.
    typedef struct {
        logic [CNT_W-1:0] s;
        logic [CNT_W-1:0] e;
        logic             up;
        int               acc;
    } mjob_t;

    mjob_t q[$];
    mjob_t cur;
    bit    cur_v = 0;
    bit    cur_err = 0;
    int    L = 0, F = 0;
    bit    last_dir = 1;
    logic [7:0] jd = 8'd0;
    int    acc_total = 0;

    // observations used by directed literal checks
    int acc_cyc = 0, done_seen_cyc = 0, err_seen_cyc = 0, load_seen_cyc = 0;
    int load_seen_val = 0;
    int done_cnt = 0, err_cnt = 0, en_cnt = 0, rst_cnt = 0, up_in_run = 0;
    bit acc_now = 0;

    bit in_job, load_e, run_e, en_e, done_e, err_e, ready_e, chnge_e;
    logic [CNT_W-1:0] ld_e;
    int n_steps;

    always @(negedge CLK) begin
        acc_now = 0;
        if (!reset) begin
            q.delete();
            cur_v = 0; last_dir = 1; jd = 8'd0; acc_total = 0;
            chk("rst_job_ready", job_ready, 1);
            chk("rst_cnt_load", cnt_load, 0);
            chk("rst_load_en", cnt_load_en, 0);
            chk("rst_chnge", cnt_chnge, 1);
            chk("rst_cnt_en", cnt_en, 0);
            chk("rst_cnt_reset", cnt_reset, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_jobs_done", jobs_done, 0);
        end else begin
            ready_e = (q.size() < DEPTH);
            in_job  = cur_v && t >= L && t <= F;
            load_e  = in_job && t == L;
            run_e   = in_job && t > L && t < F;
            en_e    = run_e && (cur_err || t < F - 1);
            done_e  = in_job && t == F && !cur_err;
            err_e   = in_job && t == F && cur_err;
            chnge_e = load_e ? cur.up : last_dir;
            ld_e    = load_e ? cur.s : '0;

            chk("job_ready", job_ready, ready_e);
            chk("cnt_load", cnt_load, ld_e);
            chk("cnt_load_en", cnt_load_en, load_e);
            chk("cnt_chnge", cnt_chnge, chnge_e);
            chk("cnt_en", cnt_en, en_e);
            chk("cnt_reset", cnt_reset, err_e);
            chk("busy", busy, in_job);
            chk("done", done, done_e);
            chk("err", err, err_e);
            chk("jobs_done", jobs_done, jd);

            if (done === 1'b1) begin done_cnt++; done_seen_cyc = t; end
            if (err === 1'b1) begin err_cnt++; err_seen_cyc = t; end
            if (cnt_load_en === 1'b1) begin load_seen_cyc = t; load_seen_val = int'(cnt_load); end
            if (cnt_en === 1'b1) en_cnt++;
            if (cnt_reset === 1'b1) rst_cnt++;
            if (cnt_en === 1'b1 && cnt_chnge === 1'b1) up_in_run++;

            // effects of the coming clock edge
            if (load_e) last_dir = cur.up;
            if (done_e) jd = jd + 8'd1;
            if (in_job && t == F) begin
                void'(q.pop_front());
                cur_v = 0;
            end
            if (job_valid && ready_e) begin
                q.push_back('{s: job_start, e: job_end, up: job_up, acc: t});
                acc_cyc = t; acc_now = 1; acc_total++;
            end
            if (!cur_v && q.size() > 0 && q[0].acc < t) begin
                cur = q[0];
                cur_v = 1;
                L = t + 1;
                n_steps = cur.up ? ((cur.e - cur.s) & MASK) : ((cur.s - cur.e) & MASK);
                if (n_steps == 0) begin
                    F = L + 1; cur_err = 0;
                end else if (freeze) begin
                    F = L + 1 + TIMEOUT; cur_err = 1;
                end else begin
                    F = L + 2 + n_steps; cur_err = 0;
                end
            end
        end
        t++;
    end

    // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
    task automatic push_job(input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] e, input logic up);
        int n = 0;
        job_valid = 1'b1; job_start = s; job_end = e; job_up = up;
        forever begin
            @(negedge CLK); #1;
            n++;
            if (acc_now) break;
            if (n > 200) begin
                chk("push_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge CLK); #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        forever begin
            @(negedge CLK); #1;
            n++;
            if (busy === 1'b0 && q.size() == 0) break;
            if (n > bound) begin
                chk("wait_idle_timeout", 0, 1);
                break;
            end
        end
        @(posedge CLK); #1;
    endtask

    int a, base_done, base_err, base_en, base_rst, rand_acc0;

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1 reset = 1'b1;

        // 1: {3,7,up}: load two cycles after accept, four counts, done 8 cycles after accept
        push_job(4'd3, 4'd7, 1'b1);
        a = acc_cyc;
        wait_idle(100);
        chk("t1_load_latency", load_seen_cyc - a, 2);
        chk("t1_load_value", load_seen_val, 3);
        chk("t1_done_latency", done_seen_cyc - a, 8);
        chk("t1_jobs_done", jobs_done, 1);

        // 2: {2,13,down}: 2,1,0,15,14,13 -> 5 counts through the wrap
        up_in_run = 0;
        push_job(4'd2, 4'd13, 1'b0);
        a = acc_cyc;
        wait_idle(100);
        chk("t2_done_latency", done_seen_cyc - a, 9);
        chk("t2_chnge_up_in_run", up_in_run, 0);
        chk("t2_jobs_done", jobs_done, 2);

        // 3: five jobs back to back while the first (15 counts) runs
        base_done = done_cnt;
        push_job(4'd0, 4'd15, 1'b1);
        push_job(4'd1, 4'd4, 1'b1);
        push_job(4'd9, 4'd6, 1'b0);
        push_job(4'd7, 4'd7, 1'b1);
        @(negedge CLK); #1;
        chk("t3_ready_low_when_full", job_ready, 0);
        @(posedge CLK); #1;
        push_job(4'd12, 4'd2, 1'b1);
        wait_idle(300);
        chk("t3_done_pulses", done_cnt - base_done, 5);
        chk("t3_jobs_done", jobs_done, 7);

        // 4: stalled counter -> watchdog drop 32 cycles after RUN entry
        freeze = 1'b1;
        base_err = err_cnt; base_rst = rst_cnt;
        push_job(4'd0, 4'd9, 1'b1);
        a = acc_cyc;
        wait_idle(200);
        freeze = 1'b0;
        chk("t4_err_latency", err_seen_cyc - a, 35);
        chk("t4_err_pulses", err_cnt - base_err, 1);
        chk("t4_cnt_reset_cycles", rst_cnt - base_rst, 1);
        chk("t4_jobs_done_unchanged", jobs_done, 7);

        // 5: start == end: LOAD then DONE, no enable
        base_en = en_cnt;
        push_job(4'd5, 4'd5, 1'b1);
        a = acc_cyc;
        wait_idle(100);
        chk("t5_done_latency", done_seen_cyc - a, 3);
        chk("t5_no_cnt_en", en_cnt - base_en, 0);
        chk("t5_jobs_done", jobs_done, 8);

        // random traffic against the model
        rand_acc0 = acc_total;
        for (int i = 0; i < 300; i++) begin
            job_valid = ($urandom_range(0, 99) < 40);
            job_start = CNT_W'($urandom_range(0, MASK));
            job_end   = CNT_W'($urandom_range(0, MASK));
            job_up    = 1'($urandom_range(0, 1));
            @(posedge CLK); #1;
        end
        job_valid = 1'b0;
        wait_idle(500);
        chk("rand_all_completed", jobs_done, (8 + acc_total - rand_acc0) & 255);

        // 6: reset in RUN with two jobs queued
        push_job(4'd0, 4'd15, 1'b1);
        push_job(4'd1, 4'd2, 1'b1);
        push_job(4'd3, 4'd4, 1'b1);
        begin
            int n = 0;
            forever begin
                @(negedge CLK); #1;
                n++;
                if (cnt_en === 1'b1) break;
                if (n > 50) begin
                    chk("t6_run_timeout", 0, 1);
                    break;
                end
            end
        end
        reset = 1'b0;
        #1;
        chk("t6_busy_in_reset", busy, 0);
        chk("t6_cnt_en_in_reset", cnt_en, 0);
        chk("t6_ready_in_reset", job_ready, 1);
        chk("t6_chnge_in_reset", cnt_chnge, 1);
        repeat (2) @(posedge CLK);
        #1 reset = 1'b1;
        base_done = done_cnt;
        push_job(4'd4, 4'd6, 1'b1);
        a = acc_cyc;
        wait_idle(100);
        chk("t6_done_latency", done_seen_cyc - a, 6);
        chk("t6_single_done", done_cnt - base_done, 1);
        chk("t6_jobs_done", jobs_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
